mc_lowpass_decim: RTL and testbench
===================================

Name: mc_lowpass_decim

Overview:
Parametrised, time-multiplexed multi-channel lowpass and decimator. It is the successor to the single-channel 7/8 leaky integrator between the SID output and the I2S encoder. It runs N channels through S cascaded one-pole stages with unity DC gain, using a single shared adder sequenced by an FSM. Every DECIM-th input sample it emits a saturated, registered output word per channel, with overrun detection.

Parameters:
WIDTH, 16, signed sample width of inputs and outputs
CHANNELS, 2, number of independent channels
STAGES, 2, cascaded one-pole stages per channel
SHIFT, 3, pole coefficient k; y += x - (y >>> k)
DECIM, 1, output produced once per DECIM accepted input samples (>=1)

Ports:
CLK  input  1  system clock (12 MHz)
RST  input  1  synchronous active-high reset
CLKen  input  1  input sample strobe (1 MHz enable)
IN  input  CHANNELS*WIDTH  packed signed inputs; channel c at [c*WIDTH +: WIDTH]
OUT  output  CHANNELS*WIDTH  packed signed filtered outputs, same packing
OUT_VALID  output  1  one-cycle pulse when OUT updates
BUSY  output  1  high while the sequencer is processing a sample
OVERRUN  output  1  sticky; set when a CLKen is dropped

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). RST has priority over all other inputs.
- Reset values: OUT=0, OUT_VALID=0, BUSY=0, OVERRUN=0, all accumulators=0, decimation counter=0, FSM=IDLE.
- Accumulator per (channel, stage): signed, WIDTH+SHIFT+1 bits, stored in a register array (RAM-inferable).
- Stage output: y_s = acc_s >>> SHIFT (arithmetic). Stage 0 input x_0 is the sign-extended latched IN channel. Stage s>0 input is y_{s-1} computed from the already-updated acc_{s-1} of the same sample.
- Update rule: acc <= acc - (acc >>> SHIFT) + x, full accumulator width, no wrap (width guarantees no overflow).
- FSM states:
  - IDLE: on CLKen, latch all of IN, set ch=0, st=0, go to RUN; BUSY=1 from the next cycle.
  - RUN: one (ch, st) update per cycle, stage-minor and channel-major order (ch0 st0, ch0 st1, ..., ch1 st0, ...). After the last update (CHANNELS*STAGES cycles), go to EMIT.
  - EMIT: increment the decimation counter. If it reaches DECIM: reset it to 0, load OUT for every channel with y_{STAGES-1} saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], and pulse OUT_VALID. Then go to IDLE; BUSY=0 in the cycle after EMIT.
- A CLKen in EMIT is accepted exactly as in IDLE (next state RUN, not IDLE).
- Latency: OUT and OUT_VALID update CHANNELS*STAGES+1 cycles after the accepted CLKen cycle.
- A CLKen in RUN is dropped: IN is not latched, filter state is unchanged, and OVERRUN is set and held until RST.
- IN may change freely after the CLKen cycle; only the latched copy is used.
- OUT holds its value between OUT_VALID pulses.
- RST mid-RUN abandons the sample. The state after RST is identical to the power-on reset state, and no OUT_VALID is produced for the abandoned sample.
- DECIM=1 means every accepted sample produces an OUT_VALID. The decimation counter counts accepted samples only; dropped samples are not counted.

Test Plan:
- Step: CHANNELS=2, STAGES=1, SHIFT=3, DECIM=1; ch0=8000, ch1=0 held, CLKen every 12 cycles -> successive ch0 OUT 1000, 1875, 2640, ... converging to 8000 (never exceeding it); ch1 OUT stays 0. OUT_VALID at CLKen+3.
- Negative and rounding: as above with ch0=-8000 -> OUT -1000, -1875, ... converging to -8000; arithmetic shift floors toward minus infinity.
- Saturation and cascade: STAGES=2, ch0=32767 sustained for 200 samples -> OUT ch0 rises monotonically and never exceeds 32767. Switch to -32768 -> output reaches no lower than -32768, with no sign-wrap glitch.
- Overrun: STAGES=2, CHANNELS=2, CLKen at cycles 0 and 2 -> second sample dropped, OVERRUN=1 from cycle 3. Exactly one OUT_VALID, at cycle 5, with values equal to the single-sample result.
- Decimation and back-to-back: DECIM=4, CLKen 16 times with each pulse landing on the EMIT cycle of the previous sample -> all 16 accepted, OVERRUN stays 0, exactly 4 OUT_VALID pulses.
- Reset mid-operation: assert RST in the 2nd RUN cycle -> next cycle BUSY=0, OUT=0, OVERRUN=0, no OUT_VALID. The next step sample reproduces the first-sample values of the Step test (1000).

Source files
------------

// File: rtl/mc_lowpass_decim.sv
// rtl/mc_lowpass_decim.sv - time-multiplexed multi-channel cascaded one-pole lowpass with decimation
//
// Purpose: runs CHANNELS independent channels through STAGES cascaded one-pole
// lowpass stages (acc += x - (acc >>> SHIFT), unity DC gain). One shared adder
// is sequenced by an FSM. A saturated output word per channel is emitted every
// DECIM accepted input samples.
//
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset, highest priority
//   CLKen      input sample strobe
//   IN         packed signed inputs, channel c at [c*WIDTH +: WIDTH]
//   OUT        packed signed filtered outputs, same packing, held between updates
//   OUT_VALID  one-cycle pulse when OUT updates
//   BUSY       high while a sample is being processed
//   OVERRUN    sticky flag, set when a strobe arrives while busy computing
module mc_lowpass_decim #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2,
   parameter int STAGES   = 2,
   parameter int SHIFT    = 3,
   parameter int DECIM    = 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         CLKen,
   input  logic [CHANNELS*WIDTH-1:0]    IN,
   output logic [CHANNELS*WIDTH-1:0]    OUT,
   output logic                         OUT_VALID,
   output logic                         BUSY,
   output logic                         OVERRUN
);

   localparam int AW    = WIDTH + SHIFT + 1;
   localparam int NSLOT = CHANNELS * STAGES;
   localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW    = (STAGES > 1)   ? $clog2(STAGES)   : 1;
   localparam int IW    = (NSLOT > 1)    ? $clog2(NSLOT)    : 1;
   localparam int DW    = (DECIM > 1)    ? $clog2(DECIM)    : 1;

   localparam logic [SW-1:0] ST_LAST   = SW'(STAGES - 1);
   localparam logic [IW-1:0] SLOT_LAST = IW'(NSLOT - 1);
   localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              ch_q;
   logic [SW-1:0]              st_q;
   logic [IW-1:0]              slot_q;
   logic [DW-1:0]              dec_q;
   logic [CHANNELS*WIDTH-1:0]  in_lat;
   logic [CHANNELS*WIDTH-1:0]  pend;
   logic signed [AW-1:0]       carry_y;
   logic signed [AW-1:0]       acc_mem [NSLOT];

   logic                       accept;
   logic                       last_st;
   logic                       last_slot;
   logic signed [WIDTH-1:0]    x_raw;
   logic signed [AW-1:0]       x_ext;
   logic signed [AW-1:0]       acc_rd;
   logic signed [AW-1:0]       acc_new;
   logic signed [AW-1:0]       y_new;
   logic [WIDTH-1:0]           y_sat;
   logic [CHANNELS*WIDTH-1:0]  out_next;

   // A strobe is taken in IDLE and also in EMIT, so back-to-back samples are not lost.
   assign accept    = CLKen && (state_q != RUN);
   assign last_st   = (st_q == ST_LAST);
   assign last_slot = (slot_q == SLOT_LAST);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (CLKen) state_d = RUN;
         RUN:     if (last_slot) state_d = EMIT;
         EMIT:    state_d = CLKen ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      BUSY = (state_q != IDLE);
   end

   // Shared datapath: one (channel, stage) accumulator update per RUN cycle.
   // Stages above 0 take the previous stage's freshly updated output from carry_y.
   always_comb begin
      x_raw   = in_lat[ch_q*WIDTH +: WIDTH];
      x_ext   = (st_q == '0) ? {{(AW-WIDTH){x_raw[WIDTH-1]}}, x_raw} : carry_y;
      acc_rd  = acc_mem[slot_q];
      acc_new = acc_rd - (acc_rd >>> SHIFT) + x_ext;
      y_new   = acc_new >>> SHIFT;
      if (y_new > SAT_MAX)      y_sat = {1'b0, {(WIDTH-1){1'b1}}};
      else if (y_new < SAT_MIN) y_sat = {1'b1, {(WIDTH-1){1'b0}}};
      else                      y_sat = y_new[WIDTH-1:0];
      // The last channel's final stage completes in the same cycle OUT is loaded.
      out_next = pend;
      out_next[ch_q*WIDTH +: WIDTH] = y_sat;
   end

   // OUT/OUT_VALID are registered on the final RUN update so that they are
   // visible during the EMIT cycle, CHANNELS*STAGES+1 cycles after the strobe.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ch_q      <= '0;
         st_q      <= '0;
         slot_q    <= '0;
         dec_q     <= '0;
         in_lat    <= '0;
         pend      <= '0;
         carry_y   <= '0;
         OUT       <= '0;
         OUT_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
         for (int i = 0; i < NSLOT; i++) acc_mem[i] <= '0;
      end else begin
         OUT_VALID <= 1'b0;
         if (CLKen && state_q == RUN) OVERRUN <= 1'b1;
         if (accept) begin
            in_lat <= IN;
            ch_q   <= '0;
            st_q   <= '0;
            slot_q <= '0;
         end else if (state_q == RUN) begin
            acc_mem[slot_q] <= acc_new;
            carry_y         <= y_new;
            slot_q          <= slot_q + 1'b1;
            if (last_st) begin
               st_q <= '0;
               ch_q <= ch_q + 1'b1;
               pend[ch_q*WIDTH +: WIDTH] <= y_sat;
            end else begin
               st_q <= st_q + 1'b1;
            end
            if (last_slot) begin
               if (dec_q == DEC_LAST) begin
                  dec_q     <= '0;
                  OUT       <= out_next;
                  OUT_VALID <= 1'b1;
               end else begin
                  dec_q <= dec_q + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mc_lowpass_decim.sv
// tb/tb_mc_lowpass_decim.sv - directed self-checking bench for mc_lowpass_decim
module tb_mc_lowpass_decim;

   logic        CLK;
   logic        RST;
   logic        CLKen;
   logic [31:0] IN;

   logic [31:0] s1_out, s2_out, d4_out;
   logic        s1_valid, s2_valid, d4_valid;
   logic        s1_busy, s2_busy, d4_busy;
   logic        s1_ovr, s2_ovr, d4_ovr;

   int checks   = 0;
   int failures = 0;

   mc_lowpass_decim #(.WIDTH(16), .CHANNELS(2), .STAGES(1), .SHIFT(3), .DECIM(1)) u_s1 (
      .CLK(CLK), .RST(RST), .CLKen(CLKen), .IN(IN),
      .OUT(s1_out), .OUT_VALID(s1_valid), .BUSY(s1_busy), .OVERRUN(s1_ovr));

   mc_lowpass_decim #(.WIDTH(16), .CHANNELS(2), .STAGES(2), .SHIFT(3), .DECIM(1)) u_s2 (
      .CLK(CLK), .RST(RST), .CLKen(CLKen), .IN(IN),
      .OUT(s2_out), .OUT_VALID(s2_valid), .BUSY(s2_busy), .OVERRUN(s2_ovr));

   mc_lowpass_decim #(.WIDTH(16), .CHANNELS(2), .STAGES(2), .SHIFT(3), .DECIM(4)) u_d4 (
      .CLK(CLK), .RST(RST), .CLKen(CLKen), .IN(IN),
      .OUT(d4_out), .OUT_VALID(d4_valid), .BUSY(d4_busy), .OVERRUN(d4_ovr));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_in(input int c0, input int c1);
      IN = {16'(c1), 16'(c0)};
   endtask

   function automatic int ch_val(input logic [31:0] bus, input int c);
      logic signed [15:0] v;
      v = bus[c*16 +: 16];
      return int'(v);
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   // Single-stage step on u_s1: 100 samples, one strobe every 12 cycles.
   task automatic step_run(input int amp, input int e0, input int e1, input int e2, input int e3);
      int exp4 [4];
      int v;
      int prev;
      exp4 = '{e0, e1, e2, e3};
      prev = 0;
      v    = 0;
      set_in(amp, 0);
      for (int k = 0; k < 100; k++) begin
         CLKen = 1'b1;
         tick();
         CLKen = 1'b0;
         if (k == 0) check("step_busy_run", int'(s1_busy), 1);
         tick();
         if (k < 4) check("step_valid_early", int'(s1_valid), 0);
         tick();
         check("step_valid", int'(s1_valid), 1);
         v = ch_val(s1_out, 0);
         if (k < 4) begin
            check("step_ch0", v, exp4[k]);
            check("step_ch1", ch_val(s1_out, 1), 0);
         end
         if (amp > 0) check("step_mono", int'(v >= prev && v <= amp), 1);
         else         check("step_mono", int'(v <= prev && v >= amp), 1);
         prev = v;
         tick();
         if (k == 0) begin
            check("step_busy_done", int'(s1_busy), 0);
            check("step_valid_pulse", int'(s1_valid), 0);
         end
         repeat (8) tick();
      end
      check("step_final", v, amp);
      check("step_hold", ch_val(s1_out, 0), amp);
   endtask

   initial begin
      int v;
      int prev;
      int cnt;
      int vcyc;
      int first;
      int got_first;

      CLKen = 1'b0;
      IN    = '0;
      RST   = 1'b1;
      tick();
      tick();
      check("rst_out", int'(s1_out), 0);
      check("rst_valid", int'(s1_valid), 0);
      check("rst_busy", int'(s1_busy), 0);
      check("rst_ovr", int'(s1_ovr), 0);
      check("rst_out_s2", int'(s2_out), 0);
      check("rst_out_d4", int'(d4_out), 0);
      RST = 1'b0;
      tick();

      // Positive and negative steps; negative floors toward minus infinity.
      step_run(8000, 1000, 1875, 2640, 3310);
      do_reset();
      step_run(-8000, -1000, -1875, -2641, -3311);

      // Saturation through the 2-stage cascade, full-scale both directions.
      do_reset();
      set_in(32767, 0);
      prev = -40000;
      v    = 0;
      for (int k = 0; k < 200; k++) begin
         CLKen = 1'b1;
         tick();
         CLKen = 1'b0;
         repeat (4) tick();
         check("sat_valid_hi", int'(s2_valid), 1);
         v = ch_val(s2_out, 0);
         check("sat_rise", int'(v >= prev), 1);
         prev = v;
         tick();
      end
      check("sat_top", v, 32767);
      set_in(-32768, 0);
      prev = 40000;
      for (int k = 0; k < 200; k++) begin
         CLKen = 1'b1;
         tick();
         CLKen = 1'b0;
         repeat (4) tick();
         check("sat_valid_lo", int'(s2_valid), 1);
         v = ch_val(s2_out, 0);
         check("sat_fall", int'(v <= prev), 1);
         prev = v;
         tick();
      end
      check("sat_bottom", v, -32768);
      check("sat_ch1", ch_val(s2_out, 1), 0);

      // Overrun: strobes at cycles 0 and 2; second one dropped.
      do_reset();
      set_in(8000, -8000);
      cnt  = 0;
      vcyc = -1;
      CLKen = 1'b1;
      tick();
      CLKen = 1'b0;
      set_in(1234, 999);
      check("ovr_valid_c1", int'(s2_valid), 0);
      tick();
      check("ovr_flag_c2", int'(s2_ovr), 0);
      check("ovr_valid_c2", int'(s2_valid), 0);
      CLKen = 1'b1;
      tick();
      CLKen = 1'b0;
      check("ovr_flag_c3", int'(s2_ovr), 1);
      for (int cyc = 3; cyc <= 14; cyc++) begin
         if (cyc > 3) tick();
         if (s2_valid) begin
            cnt++;
            vcyc = cyc;
            check("ovr_ch0", ch_val(s2_out, 0), 125);
            check("ovr_ch1", ch_val(s2_out, 1), -125);
         end
      end
      check("ovr_valid_count", cnt, 1);
      check("ovr_valid_cycle", vcyc, 5);
      check("ovr_sticky", int'(s2_ovr), 1);

      // Decimation by 4 with each strobe landing on the previous EMIT cycle.
      do_reset();
      set_in(8000, 0);
      cnt       = 0;
      first     = 0;
      got_first = 0;
      for (int s = 0; s < 16; s++) begin
         CLKen = 1'b1;
         tick();
         CLKen = 1'b0;
         for (int j = 0; j < 5; j++) begin
            if (j > 0) tick();
            if (d4_valid) begin
               cnt++;
               if (got_first == 0) begin
                  first     = ch_val(d4_out, 0);
                  got_first = 1;
               end
            end
         end
      end
      for (int j = 0; j < 10; j++) begin
         tick();
         if (d4_valid) cnt++;
      end
      check("dec_valid_count", cnt, 4);
      check("dec_ovr", int'(d4_ovr), 0);
      check("dec_first", first, 965);

      // Reset in the 2nd RUN cycle, with OVERRUN set beforehand.
      set_in(8000, 0);
      CLKen = 1'b1;
      tick();
      tick();
      CLKen = 1'b0;
      RST   = 1'b1;
      check("rmid_ovr_pre", int'(s1_ovr), 1);
      tick();
      RST = 1'b0;
      check("rmid_busy", int'(s1_busy), 0);
      check("rmid_out", int'(s1_out), 0);
      check("rmid_ovr", int'(s1_ovr), 0);
      check("rmid_valid", int'(s1_valid), 0);
      cnt = 0;
      for (int j = 0; j < 5; j++) begin
         tick();
         if (s1_valid) cnt++;
      end
      check("rmid_no_valid", cnt, 0);
      CLKen = 1'b1;
      tick();
      CLKen = 1'b0;
      tick();
      tick();
      check("rmid_after_valid", int'(s1_valid), 1);
      check("rmid_after_ch0", ch_val(s1_out, 0), 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
